// File: rtl/pattern_tx.sv
// Serial bit-pattern transmitter: sends a latched WIDTH-bit pattern MSB-first,
// a programmable number of times, with an optional fixed idle gap between repetitions.
module pattern_tx #(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned GAP      = 0,
  parameter logic        IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] pattern,
  // "repeat" is a reserved word in SystemVerilog, hence the suffix.
  input  logic [CNT_W-1:0] repeat_cnt,
  output logic             out,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned      BIT_W    = $clog2(WIDTH) + 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH);
  localparam logic [7:0]       GAP_LEN  = 8'(GAP);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP
  } state_e;

  state_e           state_q,   state_d;
  logic [WIDTH-1:0] pat_q,     pat_d;      // latched copy used for every repetition
  logic [WIDTH-1:0] shift_q,   shift_d;    // bits still to send in this repetition
  logic [CNT_W-1:0] rep_q,     rep_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;  // bits already placed on out this repetition
  logic [7:0]       gap_cnt_q, gap_cnt_d;
  logic             out_q,     out_d;
  logic             valid_q,   valid_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    shift_d   = shift_q;
    rep_d     = rep_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    out_d     = IDLE_BIT;
    valid_d   = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // The accepting edge already produces the first bit.
        if (start && (repeat_cnt != '0)) begin
          state_d   = ST_SEND;
          pat_d     = pattern;
          rep_d     = repeat_cnt;
          out_d     = pattern[WIDTH-1];
          shift_d   = pattern << 1;
          bit_cnt_d = BIT_W'(1);
          gap_cnt_d = '0;
          valid_d   = 1'b1;
          busy_d    = 1'b1;
        end
      end

      ST_SEND: begin
        if (abort) begin
          state_d   = ST_IDLE;
          rep_d     = '0;
          bit_cnt_d = '0;
          gap_cnt_d = '0;
        end else if (bit_cnt_q != LAST_BIT) begin
          out_d     = shift_q[WIDTH-1];
          shift_d   = shift_q << 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          valid_d   = 1'b1;
          busy_d    = 1'b1;
        end else begin
          // Last bit of a repetition is on out now.
          rep_d = rep_q - 1'b1;
          if (rep_q == CNT_W'(1)) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            done_d    = 1'b1;
          end else if (GAP_LEN != 8'd0) begin
            state_d   = ST_GAP;
            bit_cnt_d = '0;
            gap_cnt_d = 8'd1;
            busy_d    = 1'b1;
          end else begin
            out_d     = pat_q[WIDTH-1];
            shift_d   = pat_q << 1;
            bit_cnt_d = BIT_W'(1);
            valid_d   = 1'b1;
            busy_d    = 1'b1;
          end
        end
      end

      ST_GAP: begin
        if (abort) begin
          state_d   = ST_IDLE;
          rep_d     = '0;
          bit_cnt_d = '0;
          gap_cnt_d = '0;
        end else if (gap_cnt_q == GAP_LEN) begin
          state_d   = ST_SEND;
          out_d     = pat_q[WIDTH-1];
          shift_d   = pat_q << 1;
          bit_cnt_d = BIT_W'(1);
          gap_cnt_d = '0;
          valid_d   = 1'b1;
          busy_d    = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
          busy_d    = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pat_q     <= '0;
      shift_q   <= '0;
      rep_q     <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      out_q     <= IDLE_BIT;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      shift_q   <= shift_d;
      rep_q     <= rep_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign out   = out_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_pattern_tx.sv
// Directed bench for pattern_tx: a vector table on the default instance plus
// hand-written sequences for the gapped and WIDTH=1 instances.
module tb_pattern_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: defaults (WIDTH=3, CNT_W=4, GAP=0, IDLE_BIT=0)
  logic       r0 = 1'b1, s0 = 1'b0, a0 = 1'b0;
  logic [2:0] p0 = '0;
  logic [3:0] n0 = '0;
  logic       o0, v0, b0, d0;

  // Instance 1: GAP=2, IDLE_BIT=1
  logic       r1 = 1'b1, s1 = 1'b0, a1 = 1'b0;
  logic [2:0] p1 = '0;
  logic [3:0] n1 = '0;
  logic       o1, v1, b1, d1;

  // Instance 2: WIDTH=1
  logic       r2 = 1'b1, s2 = 1'b0, a2 = 1'b0;
  logic [0:0] p2 = '0;
  logic [3:0] n2 = '0;
  logic       o2, v2, b2, d2;

  pattern_tx u0 (
    .clk(clk), .reset(r0), .start(s0), .abort(a0), .pattern(p0), .repeat_cnt(n0),
    .out(o0), .valid(v0), .busy(b0), .done(d0)
  );

  pattern_tx #(.WIDTH(3), .CNT_W(4), .GAP(2), .IDLE_BIT(1'b1)) u1 (
    .clk(clk), .reset(r1), .start(s1), .abort(a1), .pattern(p1), .repeat_cnt(n1),
    .out(o1), .valid(v1), .busy(b1), .done(d1)
  );

  pattern_tx #(.WIDTH(1), .CNT_W(4), .GAP(0), .IDLE_BIT(1'b0)) u2 (
    .clk(clk), .reset(r2), .start(s2), .abort(a2), .pattern(p2), .repeat_cnt(n2),
    .out(o2), .valid(v2), .busy(b2), .done(d2)
  );

  typedef struct {
    logic       rst;
    logic       st;
    logic       ab;
    logic [2:0] pat;
    logic [3:0] rep;
    logic [3:0] exp;  // {out, valid, busy, done} after the edge
    string      tag;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (out/valid/busy/done packed as hex nibble)",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic rst, input logic st, input logic ab,
                              input logic [2:0] pat, input logic [3:0] rep,
                              input logic [3:0] exp, input string tag);
    vec_t v;
    v.rst = rst; v.st = st; v.ab = ab; v.pat = pat; v.rep = rep; v.exp = exp; v.tag = tag;
    vecs.push_back(v);
  endfunction

  task automatic fill_table();
    logic [8:0] bits9;
    // 1: single repetition of 101
    add(1, 0, 0, 3'b000, 4'd0, 4'b0000, "t1_reset");
    add(1, 0, 0, 3'b000, 4'd0, 4'b0000, "t1_reset2");
    add(0, 1, 0, 3'b101, 4'd1, 4'b1110, "t1_bit1");
    add(0, 0, 0, 3'b101, 4'd1, 4'b0110, "t1_bit2");
    add(0, 0, 0, 3'b101, 4'd1, 4'b1110, "t1_bit3");
    add(0, 0, 0, 3'b101, 4'd1, 4'b0001, "t1_done");
    add(0, 0, 0, 3'b101, 4'd1, 4'b0000, "t1_idle");
    // 2: three contiguous repetitions
    bits9 = 9'b101101101;
    for (int i = 8; i >= 0; i--)
      add(0, (i == 8), 0, 3'b101, 4'd3, {bits9[i], 3'b110}, $sformatf("t2_bit%0d", 9 - i));
    add(0, 0, 0, 3'b101, 4'd3, 4'b0001, "t2_done");
    add(0, 0, 0, 3'b101, 4'd3, 4'b0000, "t2_idle");
    // 4: ignored starts and mid-stream input changes
    add(0, 1, 0, 3'b101, 4'd0, 4'b0000, "t4_rep0");
    add(0, 0, 0, 3'b101, 4'd0, 4'b0000, "t4_rep0_idle");
    add(0, 1, 0, 3'b101, 4'd2, 4'b1110, "t4_bit1");
    add(0, 1, 0, 3'b010, 4'd2, 4'b0110, "t4_start_busy");
    add(0, 0, 0, 3'b010, 4'd2, 4'b1110, "t4_bit3");
    add(0, 0, 0, 3'b010, 4'd2, 4'b1110, "t4_bit4");
    add(0, 0, 0, 3'b010, 4'd2, 4'b0110, "t4_bit5");
    add(0, 0, 0, 3'b010, 4'd2, 4'b1110, "t4_bit6");
    add(0, 0, 0, 3'b010, 4'd2, 4'b0001, "t4_done");
    add(0, 0, 0, 3'b010, 4'd2, 4'b0000, "t4_idle");
    // 5: abort and reset mid-stream, abort in idle, start beats abort
    add(0, 1, 0, 3'b110, 4'd1, 4'b1110, "t5_bit1");
    add(0, 0, 0, 3'b110, 4'd1, 4'b1110, "t5_bit2");
    add(0, 0, 1, 3'b110, 4'd1, 4'b0000, "t5_abort");
    add(0, 0, 0, 3'b110, 4'd1, 4'b0000, "t5_no_done");
    add(0, 1, 0, 3'b110, 4'd1, 4'b1110, "t5r_bit1");
    add(0, 0, 0, 3'b110, 4'd1, 4'b1110, "t5r_bit2");
    add(1, 0, 0, 3'b110, 4'd1, 4'b0000, "t5_reset");
    add(0, 0, 0, 3'b110, 4'd1, 4'b0000, "t5r_no_done");
    add(0, 0, 1, 3'b110, 4'd1, 4'b0000, "abort_idle");
    add(0, 1, 1, 3'b110, 4'd1, 4'b1110, "start_wins");
    add(0, 0, 0, 3'b110, 4'd1, 4'b1110, "sw_bit2");
    add(0, 0, 0, 3'b110, 4'd1, 4'b0110, "sw_bit3");
    add(0, 0, 0, 3'b110, 4'd1, 4'b0001, "sw_done");
    add(0, 0, 0, 3'b110, 4'd1, 4'b0000, "sw_idle");
    // 6: start held high -> back-to-back streams
    for (int k = 0; k < 2; k++) begin
      add(0, 1, 0, 3'b011, 4'd1, 4'b0110, $sformatf("t6_s%0d_bit1", k));
      add(0, 1, 0, 3'b011, 4'd1, 4'b1110, $sformatf("t6_s%0d_bit2", k));
      add(0, 1, 0, 3'b011, 4'd1, 4'b1110, $sformatf("t6_s%0d_bit3", k));
      add(0, 1, 0, 3'b011, 4'd1, 4'b0001, $sformatf("t6_s%0d_done", k));
    end
    add(0, 0, 0, 3'b011, 4'd1, 4'b0000, "t6_idle");
  endtask

  initial begin
    logic [7:0] g_out, g_val;
    int         nvalid;

    // Common reset of all instances
    step();
    step();
    check("rst_u0", {o0, v0, b0, d0}, 4'b0000);
    check("rst_u1", {o1, v1, b1, d1}, 4'b1000);
    check("rst_u2", {o2, v2, b2, d2}, 4'b0000);
    r0 = 1'b0; r1 = 1'b0; r2 = 1'b0;

    // Table-driven run on instance 0
    fill_table();
    foreach (vecs[i]) begin
      r0 = vecs[i].rst; s0 = vecs[i].st; a0 = vecs[i].ab;
      p0 = vecs[i].pat; n0 = vecs[i].rep;
      step();
      check(vecs[i].tag, {o0, v0, b0, d0}, vecs[i].exp);
    end
    s0 = 1'b0; a0 = 1'b0; r0 = 1'b0;

    // 3: GAP=2, IDLE_BIT=1, pattern 101 twice
    g_out = 8'b10111101;
    g_val = 8'b11100111;
    s1 = 1'b1; p1 = 3'b101; n1 = 4'd2;
    for (int c = 7; c >= 0; c--) begin
      step();
      s1 = 1'b0;
      check($sformatf("t3_cyc%0d", 8 - c), {o1, v1, b1, d1}, {g_out[c], g_val[c], 2'b10});
    end
    step();
    check("t3_done", {o1, v1, b1, d1}, 4'b1001);
    step();
    check("t3_idle", {o1, v1, b1, d1}, 4'b1000);

    // Abort during the gap
    s1 = 1'b1; p1 = 3'b100; n1 = 4'd2;
    step();
    s1 = 1'b0;
    check("gab_bit1", {o1, v1, b1, d1}, 4'b1110);
    step();
    check("gab_bit2", {o1, v1, b1, d1}, 4'b0110);
    step();
    check("gab_bit3", {o1, v1, b1, d1}, 4'b0110);
    step();
    check("gab_gap1", {o1, v1, b1, d1}, 4'b1010);
    a1 = 1'b1;
    step();
    a1 = 1'b0;
    check("gab_abort", {o1, v1, b1, d1}, 4'b1000);
    for (int c = 0; c < 3; c++) begin
      step();
      check("gab_no_done", {o1, v1, b1, d1}, 4'b1000);
    end

    // WIDTH=1 with maximum repeat count
    nvalid = 0;
    s2 = 1'b1; p2 = 1'b1; n2 = 4'd15;
    for (int c = 0; c < 15; c++) begin
      step();
      s2 = 1'b0;
      if (v2) nvalid++;
      check($sformatf("w1_bit%0d", c + 1), {o2, v2, b2, d2}, 4'b1110);
    end
    step();
    check("w1_done", {o2, v2, b2, d2}, 4'b0001);
    check("w1_count", nvalid, 15);
    step();
    check("w1_idle", {o2, v2, b2, d2}, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
